// File: rtl/rgb_feeder_pkg.sv
// Shared types and word-packing helpers for the RGB BRAM feeder.
// A stream word carries three 16-bit channels with the top 16 bits held at zero.
package rgb_feeder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} feeder_state_t;

  localparam int R_LSB      = 32;
  localparam int G_LSB      = 16;
  localparam int B_LSB      = 0;
  localparam int PAD_HI_MSB = 63;
  localparam int PAD_HI_LSB = 48;
  localparam int WORD_W     = 64;
  localparam int FIFO_W     = WORD_W + 1;

  function automatic logic [WORD_W-1:0] pack_rgb(input logic [15:0] r,
                                                 input logic [15:0] g,
                                                 input logic [15:0] b);
    logic [WORD_W-1:0] w;
    w = '0;
    w[R_LSB +: 16] = r;
    w[G_LSB +: 16] = g;
    w[B_LSB +: 16] = b;
    w[PAD_HI_MSB:PAD_HI_LSB] = 16'd0;
    return w;
  endfunction

endpackage

// File: rtl/feeder_skid_fifo.sv
// Two-entry skid FIFO that absorbs the reads still in flight when the consumer stalls.
// A simultaneous push and pop on a full FIFO is accepted and leaves occupancy unchanged.
module feeder_skid_fifo
  import rgb_feeder_pkg::*;
(
  input  logic              clk_fast,
  input  logic              reset,
  input  logic              push,
  input  logic [FIFO_W-1:0] push_data,
  input  logic              pop,
  output logic [FIFO_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [1:0]        occ
);

  logic [FIFO_W-1:0] mem [0:1];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (occ == 2'd2);
  assign empty    = (occ == 2'd0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/rgb_bram_feeder.sv
// Streams one RGB image from three channel BRAMs as packed 64-bit words, zero-padded to a
// burst multiple, with credit-based issue so that stalled reads always fit in the skid FIFO.
module rgb_bram_feeder
  import rgb_feeder_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int PIX_W    = 16,
  parameter int MAX_PIX  = 7056,
  parameter int PAD_MULT = 8
) (
  input  logic              clk_fast,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_size,
  input  logic              busy,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [PIX_W-1:0]  dout_r,
  input  logic [PIX_W-1:0]  dout_g,
  input  logic [PIX_W-1:0]  dout_b,
  output logic [63:0]       rdata,
  output logic              rdata_valid,
  output logic              active,
  output logic              done,
  output logic              cfg_err
);

  feeder_state_t     state, state_next;
  logic [15:0]       idx, pop_cnt, npix, total;
  logic [15:0]       size_sq, total_new;
  logic              size_ok;
  logic              inflight, inflight_zero;
  logic              issue, credit, pop, last_pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        outstanding;
  logic [FIFO_W-1:0] fifo_dout;

  assign size_sq   = {8'd0, in_size} * {8'd0, in_size};
  assign size_ok   = (in_size != 8'd0) && (size_sq <= 16'(MAX_PIX));
  assign total_new = (size_sq + 16'(PAD_MULT - 1)) & ~16'(PAD_MULT - 1);

  // The spare FIFO bit marks padding slots, so those words read as zero regardless of BRAM data.
  assign rdata_valid = !fifo_empty;
  assign rdata       = (rdata_valid && !fifo_dout[FIFO_W-1]) ? fifo_dout[63:0] : 64'd0;
  assign pop         = rdata_valid && !busy;
  assign last_pop    = (state == DRAIN) && pop && (pop_cnt == total - 16'd1);
  assign active      = (state != IDLE);

  // Outstanding = words held plus the read in flight; at two, only a pop this cycle frees a slot.
  assign outstanding = {1'b0, occ} + {2'b0, inflight};
  assign credit      = (outstanding < 3'd2) || (pop && (fifo_full || inflight));

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    bram_en    = 1'b0;
    bram_addr  = '0;
    case (state)
      IDLE:    if (start && size_ok) state_next = RUN;
      RUN: begin
        issue = credit;
        if (issue && (idx == total - 16'd1)) state_next = DRAIN;
      end
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (issue && (idx < npix)) begin
      bram_en   = 1'b1;
      bram_addr = idx[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      idx           <= 16'd0;
      pop_cnt       <= 16'd0;
      npix          <= 16'd0;
      total         <= 16'd0;
      inflight      <= 1'b0;
      inflight_zero <= 1'b0;
      cfg_err       <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= last_pop;
      inflight      <= issue;
      inflight_zero <= issue && (idx >= npix);
      if (state == IDLE) begin
        if (start) begin
          if (size_ok) begin
            npix    <= size_sq;
            total   <= total_new;
            idx     <= 16'd0;
            pop_cnt <= 16'd0;
            cfg_err <= 1'b0;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      end else begin
        if (issue) idx     <= idx + 16'd1;
        if (pop)   pop_cnt <= pop_cnt + 16'd1;
      end
    end
  end

  feeder_skid_fifo u_fifo (
    .clk_fast  (clk_fast),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_zero, pack_rgb(dout_r, dout_g, dout_b)}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occ       (occ)
  );

endmodule

// File: tb/tb_rgb_bram_feeder.sv
// Directed bench for rgb_bram_feeder: BRAM model returns R=addr, G=addr+1, B=addr+2 and
// every frame is scored word by word against hand-derived expectations.
module tb_rgb_bram_feeder;

  localparam int ADDR_W = 13;

  logic              clk_fast = 1'b0;
  logic              reset    = 1'b0;
  logic              start    = 1'b0;
  logic              busy     = 1'b0;
  logic [7:0]        in_size  = 8'd0;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [15:0]       dout_r, dout_g, dout_b;
  logic [63:0]       rdata;
  logic              rdata_valid, active, done, cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) begin
    if (bram_en) begin
      dout_r <= 16'(bram_addr);
      dout_g <= 16'(bram_addr) + 16'd1;
      dout_b <= 16'(bram_addr) + 16'd2;
    end
  end

  rgb_bram_feeder dut (
    .clk_fast    (clk_fast),
    .reset       (reset),
    .start       (start),
    .in_size     (in_size),
    .busy        (busy),
    .bram_en     (bram_en),
    .bram_addr   (bram_addr),
    .dout_r      (dout_r),
    .dout_g      (dout_g),
    .dout_b      (dout_b),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .active      (active),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #2;
  endtask

  function automatic logic [63:0] exp_word(input int k, input int npix);
    if (k < npix) return {16'd0, 16'(k), 16'(k + 1), 16'(k + 2)};
    return 64'd0;
  endfunction

  // mode 0: busy low; mode 1: random busy plus ignored starts; mode 2: busy high for 20 cycles
  task automatic run_frame(input int size, input int mode, input int abort_at,
                           output bit aborted);
    int npix, total, budget, cycle, hs, en_cnt, en_early, first_valid, last_hs;
    int word_err, addr_err, done_ok, done_bad, hold_err, out_err, gap_err;
    bit prev_stall, finished, start_ok;
    logic [63:0] prev_word;
    npix = size * size;
    total = ((npix + 7) / 8) * 8;
    budget = total * 4 + 60;
    hs = 0; en_cnt = 0; en_early = 0; first_valid = -1; last_hs = -10;
    word_err = 0; addr_err = 0; done_ok = 0; done_bad = 0;
    hold_err = 0; out_err = 0; gap_err = 0;
    prev_stall = 1'b0; finished = 1'b0; start_ok = 1'b0; prev_word = 64'd0;
    aborted = 1'b0;
    in_size = 8'(size);
    start = 1'b1;
    busy = (mode == 2);
    tick();
    start = 1'b0;
    cycle = 0;
    while (!finished && cycle < budget) begin
      case (mode)
        1: begin
          busy = 1'($urandom_range(0, 1));
          if (hs < total) begin
            start = 1'($urandom_range(0, 1));
            in_size = 8'($urandom);
          end else start = 1'b0;
        end
        2: busy = (cycle < 20);
        default: busy = 1'b0;
      endcase
      #1;
      if (cycle == 0) start_ok = (active === 1'b1 && cfg_err === 1'b0);
      if (bram_en === 1'b1) begin
        if (int'(bram_addr) != en_cnt || int'(bram_addr) >= npix) addr_err++;
        en_cnt++;
        if (cycle < 20) en_early++;
      end
      if (done === 1'b1) begin
        if (hs == total && cycle == last_hs + 1) done_ok++;
        else done_bad++;
      end
      if (prev_stall && !(rdata_valid === 1'b1 && rdata === prev_word)) hold_err++;
      if (rdata_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cycle;
      end else if (mode != 1 && first_valid >= 0 && hs < total) gap_err++;
      if (rdata_valid === 1'b1 && busy == 1'b0) begin
        if (rdata !== exp_word(hs, npix)) word_err++;
        hs++;
        last_hs = cycle;
      end
      if (en_cnt - hs > 2) out_err++;
      prev_stall = (rdata_valid === 1'b1) && busy;
      prev_word = rdata;
      if (abort_at >= 0 && hs == abort_at) aborted = 1'b1;
      if (aborted || (hs >= total && cycle >= last_hs + 3)) finished = 1'b1;
      else begin
        tick();
        cycle++;
      end
    end
    busy = 1'b0;
    start = 1'b0;
    check_output($sformatf("timeout_s%0d_m%0d", size, mode), 64'(!finished), 64'd0);
    check_output($sformatf("start_accept_s%0d", size), 64'(start_ok), 64'd1);
    check_output($sformatf("word_data_s%0d_m%0d", size, mode), 64'(word_err), 64'd0);
    check_output($sformatf("first_valid_s%0d_m%0d", size, mode), 64'(first_valid), 64'd2);
    if (!aborted) begin
      check_output($sformatf("word_count_s%0d_m%0d", size, mode), 64'(hs), 64'(total));
      check_output($sformatf("en_count_s%0d_m%0d", size, mode), 64'(en_cnt), 64'(npix));
      check_output($sformatf("addr_seq_s%0d_m%0d", size, mode), 64'(addr_err), 64'd0);
      check_output($sformatf("done_once_s%0d_m%0d", size, mode),
                   {32'(done_ok), 32'(done_bad)}, {32'd1, 32'd0});
      check_output($sformatf("hold_s%0d_m%0d", size, mode), 64'(hold_err), 64'd0);
      check_output($sformatf("outstanding_s%0d_m%0d", size, mode), 64'(out_err), 64'd0);
      check_output($sformatf("gaps_s%0d_m%0d", size, mode), 64'(gap_err), 64'd0);
      check_output($sformatf("active_end_s%0d", size), 64'(active), 64'd0);
      if (mode == 2) check_output("en_pulses_while_busy", 64'(en_early), 64'd2);
    end
  endtask

  initial begin
    bit ab;
    int cnt;

    $display("[TB] reset check");
    tick();
    tick();
    check_output("reset_rdata", rdata, 64'd0);
    check_output("reset_ctrl", 64'({rdata_valid, bram_en, bram_addr, active, done, cfg_err}), 64'd0);
    reset = 1'b1;
    tick();

    $display("[TB] full 84x84 frame, no stall");
    run_frame(84, 0, -1, ab);

    $display("[TB] 3x3 frame with padding");
    run_frame(3, 0, -1, ab);

    $display("[TB] rejected starts");
    in_size = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check_output("size0_cfg_err", 64'({cfg_err, active}), 64'b10);
    tick();
    in_size = 8'd85;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bram_en !== 1'b0 || active !== 1'b0) cnt++;
      if (i == 0) check_output("size85_cfg_err", 64'({cfg_err, active}), 64'b10);
      tick();
    end
    check_output("size85_idle", 64'(cnt), 64'd0);

    $display("[TB] 4x4 frame clears cfg_err");
    run_frame(4, 0, -1, ab);

    $display("[TB] 84x84 frame, random busy");
    run_frame(84, 1, -1, ab);

    $display("[TB] busy held for 20 cycles after start");
    run_frame(8, 2, -1, ab);

    $display("[TB] reset mid-frame");
    run_frame(84, 0, 100, ab);
    check_output("abort_reached", 64'(ab), 64'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("midrst_rdata", rdata, 64'd0);
      check_output("midrst_ctrl",
                   64'({rdata_valid, bram_en, bram_addr, active, done, cfg_err}), 64'd0);
      tick();
    end
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (done !== 1'b0 || rdata_valid !== 1'b0) cnt++;
      tick();
    end
    check_output("no_done_after_abort", 64'(cnt), 64'd0);
    run_frame(8, 0, -1, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_bram_feeder.md
# rgb_bram_feeder

Streams one RGB image from the three channel BRAMs (R/G/B, 1-cycle read latency) into the 64-bit word stream consumed on the PS_BRAM_rdata path of Top. It sequences raster-order BRAM reads, packs the three channels into one word, and zero-pads the stream to a burst multiple. It honours the consumer's busy stall through a 2-entry skid FIFO, so no read is ever lost.

## Interface
- ADDR_W, 13, BRAM address width (8192 locations)
- PIX_W, 16, width of each channel sample
- MAX_PIX, 7056, largest legal pixel count (84x84)
- PAD_MULT, 8, stream length is rounded up to a multiple of this; power of 2
- clk_fast  in  1  clock; BRAMs share it
- reset  in  1  asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- in_size  in  8  image side length; pixel count = in_size*in_size
- busy  in  1  consumer stall; while high, no word is consumed
- bram_en  out  1  read enable to all three BRAMs
- bram_addr  out  ADDR_W  read address to all three BRAMs
- dout_r, dout_g, dout_b  in  PIX_W each  BRAM read data, valid the cycle after the enable edge
- rdata  out  64  {16'd0, R, G, B}; bits [63:48] are always 0
- rdata_valid  out  1  rdata holds a word
- active  out  1  frame in progress
- done  out  1  one-cycle pulse after the last word is consumed
- cfg_err  out  1  last start was rejected; sticky until the next accepted start or reset

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, start=1:
  - If in_size=0 or npix>MAX_PIX: set cfg_err=1 and stay IDLE.
  - Otherwise latch npix=in_size*in_size (16 bit) and total=npix rounded up to PAD_MULT. Clear idx, cfg_err and counters, set active, go RUN.
- RUN: issue index idx when credit allows (see Timing).
  - idx<npix: bram_en=1, bram_addr=idx.
  - idx>=npix: bram_en=0, a zero word is scheduled.
  - An in-flight tag bit records which case applies, so ordering is preserved.
  - After idx=total-1 is issued, go DRAIN.
- DRAIN: no issues. When the word total-1 is popped: done=1 for one cycle, active=0, go IDLE.
- Consume: a word is popped when rdata_valid=1 and busy=0. rdata is stable while rdata_valid=1 and busy=1.
- start outside IDLE is ignored. in_size is only sampled on an accepted start.
- Arithmetic: idx and the pop counter are 16 bits. bram_addr=idx[ADDR_W-1:0] and is only driven with idx<npix<=MAX_PIX.
- Reset values: every output is 0, state is IDLE, FIFO is empty, the in-flight flag is clear.
- Reset mid-frame aborts immediately with no done pulse. Any outstanding BRAM data is discarded.

## Timing
- bram_en and bram_addr are combinational from registered state, idx and credit.
- BRAM data is pushed into the FIFO on the edge after the enable edge. rdata_valid is driven from FIFO occupancy (registered).
- Latency: start sampled at edge E0 → bram_en=1, addr=0 in cycle E0..E1 → word pushed at E2 → rdata_valid=1 after E2.
- Credit rule: issue only if occ+inflight<2, or occ+inflight=2 with a pop in the same cycle.
  - inflight ≤ 1; FIFO depth is 2.
  - Sustained throughput is 1 word/cycle while busy=0.
  - At most 2 reads are outstanding when busy rises; both land in the FIFO.
- Push and pop in the same cycle on a full FIFO are legal; occupancy is unchanged.
- Pop on an empty FIFO cannot occur.
- done asserts on the edge following the final pop, i.e. the cycle after the final handshake.
- Frame length is exactly total handshakes. A new start is accepted the cycle after done.

## Structure
- Package rgb_feeder_pkg holds:
  - state enum (IDLE/RUN/DRAIN)
  - field offsets R_LSB=32, G_LSB=16, B_LSB=0, and PAD_HI=[63:48]
  - the pack function {16'd0,r,g,b}
- Sub-module feeder_skid_fifo: 2-entry, 65-bit (64-bit word plus spare), with push/pop/full/empty and occupancy output.
- The top level holds the FSM, index/pop counters, credit logic, the in-flight tag and zero/BRAM data selection.

## Test plan
- in_size=84, busy=0, BRAMs with R=addr, G=addr+1, B=addr+2:
  - Exactly 7056 words, word k={0,k,k+1,k+2}.
  - rdata_valid is continuous from 2 cycles after start; done follows the last word by 1 cycle.
- in_size=3: 16 words; words 0..8 hold data, words 9..15 are 64'h0; bram_en is never high with addr≥9.
- in_size=85 start: cfg_err=1, active=0, no bram_en. A following in_size=4 start clears cfg_err and streams 16 words.
- Random busy (50%) during in_size=84: no dropped or duplicated words, rdata is held while stalled, and outstanding reads never exceed FIFO space.
- busy held high for 20 cycles right after start: bram_en pulses exactly twice, then stops. On release, words 0,1,2… follow back-to-back.
- reset low at word 100, released, new start with in_size=8: all outputs are 0 during reset, no done pulse, the new frame begins at addr 0 with 64 clean words.
